key_press_pulser: RTL and testbench

//  Conditions one raw player pushbutton into a clean single-cycle press event.

---
 rtl/key_press_pulser.sv | 110 +++++++++++
 tb/tb_key_press_pulser.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/key_press_pulser.sv
// Turns one raw, bouncing pushbutton into a clean single-cycle press event.
// Path: synchronizer -> press/release debounce FSM -> registered pulse and press tally.
module key_press_pulser #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int COUNT_W         = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               key_raw,
  input  logic               enable,
  output logic               press_pulse,
  output logic               key_held,
  output logic [COUNT_W-1:0] press_count,
  output logic [1:0]         fsm_state
);

  localparam logic           RELEASED_LVL = (ACTIVE_LOW != 0);
  localparam int             CW           = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST     = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pressed;
  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   fire;

  // Flops start at the released level so reset never looks like a press.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) sync_q <= {SYNC_STAGES{RELEASED_LVL}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw};
  end

  assign pressed = sync_q[SYNC_STAGES-1] ^ RELEASED_LVL;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fire      = 1'b0;
    case (state)
      RELEASED: begin
        if (pressed) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          fire      = enable;
        end else begin
          cnt_nxt   = cnt + CW'(1);
        end
      end
      HELD: begin
        if (!pressed) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CW'(1);
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed resumes HELD without a new pulse.
        if (pressed) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state       <= RELEASED;
      cnt         <= '0;
      press_pulse <= 1'b0;
      key_held    <= 1'b0;
      press_count <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      press_pulse <= fire;
      key_held    <= (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
      press_count <= press_count + COUNT_W'(fire);
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_key_press_pulser.sv
// Bench for key_press_pulser: directed scenarios plus random bursts, checked every
// cycle against a run-length debounce model; a COUNT_W=4 twin exercises counter wrap.
module tb_key_press_pulser;

  localparam int SYNC = 2;
  localparam int DEB  = 4;

  logic       Clock;
  logic       Reset;
  logic       key_raw;
  logic       enable;
  logic       press_pulse, key_held;
  logic [7:0] press_count;
  logic [1:0] fsm_state;
  logic       pulse4, held4;
  logic [3:0] count4;
  logic [1:0] state4;

  int n_cmp = 0;
  int n_bad = 0;

  key_press_pulser #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1), .COUNT_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .key_raw(key_raw), .enable(enable),
    .press_pulse(press_pulse), .key_held(key_held), .press_count(press_count),
    .fsm_state(fsm_state)
  );

  key_press_pulser #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(1), .COUNT_W(4)) dut4 (
    .Clock(Clock), .Reset(Reset), .key_raw(key_raw), .enable(enable),
    .press_pulse(pulse4), .key_held(held4), .press_count(count4),
    .fsm_state(state4)
  );

  // Clock and reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: the level the debouncer sees lags key_raw by SYNC edges; the
  // debounced level flips once DEB consecutive visible samples disagree with it.
  bit m_pipe[SYNC];
  bit m_held, m_pulse;
  int m_run, m_count;

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
    m_held = 0; m_pulse = 0; m_run = 0; m_count = 0;
  endtask

  task automatic model_step(input bit raw, input bit en);
    bit vis;
    vis = m_pipe[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = ~raw;
    m_pulse = 0;
    if (vis != m_held) m_run++;
    else m_run = 0;
    if (m_run == DEB) begin
      m_held = vis;
      m_run  = 0;
      if (vis && en) begin
        m_pulse = 1;
        m_count++;
      end
    end
  endtask

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("press_pulse", 32'(press_pulse), 32'(m_pulse));
    check("key_held",    32'(key_held),    32'(m_held));
    check("press_count", 32'(press_count), 32'(m_count % 256));
    check("count4",      32'(count4),      32'(m_count % 16));
    check("pulse4",      32'(pulse4),      32'(m_pulse));
  endtask

  // Driver: apply inputs, take one edge, advance model, sample 1 time unit later.
  task automatic edge_step(input bit raw, input bit en);
    key_raw = raw;
    enable  = en;
    @(posedge Clock);
    model_step(raw, en);
    #1;
    check_all();
  endtask

  task automatic run(input bit raw, input bit en, input int n);
    for (int i = 0; i < n; i++) edge_step(raw, en);
  endtask

  task automatic do_reset();
    @(negedge Clock);
    Reset = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  int pulses17;

  initial begin
    Reset = 1'b1; key_raw = 1'b1; enable = 1'b1;
    model_reset();
    repeat (2) @(posedge Clock);
    #1;
    check_all();
    check("reset_state", 32'(fsm_state), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    // Clean press, then release; pulse after edge 6, release seen 6 edges later
    run(1, 1, 3);
    run(0, 1, 12);
    run(1, 1, 10);

    // Press bounce rejected
    run(0, 1, 3); run(1, 1, 1); run(0, 1, 3); run(1, 1, 10);

    // Release bounce: one pulse, key_held stays up
    run(0, 1, 10); run(1, 1, 2); run(0, 1, 5); run(1, 1, 10);

    // enable low for a whole press, then raised while held
    run(0, 0, 12); run(1, 0, 10);
    run(0, 0, 8);  run(0, 1, 6); run(1, 1, 10);

    // Async reset during PRESS_WAIT, key kept down: new pulse 6 edges after release
    run(0, 1, 4);
    check("in_press_wait", 32'(fsm_state), 32'd1);
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    check_all();
    check("reset_fsm", 32'(fsm_state), 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    run(0, 1, 10);
    run(1, 1, 10);

    // Random bursts
    for (int b = 0; b < 120; b++)
      run(1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0), $urandom_range(1, 10));
    run(1, 1, 10);

    // Seventeen clean presses: 4-bit twin wraps 15 -> 0 -> 1
    do_reset();
    pulses17 = 0;
    for (int p = 0; p < 17; p++) begin
      for (int i = 0; i < 7; i++) begin
        edge_step(0, 1);
        if (pulse4) pulses17++;
      end
      run(1, 1, 8);
      check("count4_seq", 32'(count4), 32'((p + 1) % 16));
    end
    check("pulses17", 32'(pulses17), 32'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
